// File: rtl/riscv_mdu_pkg.sv
// rtl/riscv_mdu_pkg.sv - shared constants and types for the RV32M divide unit
// Contents: XLEN, funct3 encodings for DIV/DIVU/REM/REMU, divider FSM state enum.
package riscv_mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - ID/EX-to-divider request and result/stall signals
// master: pipeline side (drives start/funct3/operands/flush, sees indication/result/result_valid)
// slave : divider side (the reverse directions)
interface div_unit_if;

  logic                               start;
  logic [2:0]                         funct3;
  logic [riscv_mdu_pkg::XLEN-1:0]     operand_a;
  logic [riscv_mdu_pkg::XLEN-1:0]     operand_b;
  logic                               flush;
  logic                               indication;
  logic [riscv_mdu_pkg::XLEN-1:0]     result;
  logic                               result_valid;

  modport master (
    output start, funct3, operand_a, operand_b, flush,
    input  indication, result, result_valid
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, flush,
    output indication, result, result_valid
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
// Ports: rem_i (33b partial remainder), dividend_msb_i (next dividend bit), divisor_i (|b|)
//        rem_o (next partial remainder), quot_bit_o (quotient bit produced this step)
module div_step
  import riscv_mdu_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic            dividend_msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            quot_bit_o
);

  logic [XLEN+1:0] diff;

  // Full-width trial subtract; the top bit of diff is the borrow/sign.
  // rem_i is always below the divisor, so its MSB is zero and the shift never overflows.
  assign diff       = {rem_i, dividend_msb_i} - {2'b00, divisor_i};
  assign quot_bit_o = ~diff[XLEN+1];
  assign rem_o      = quot_bit_o ? diff[XLEN:0] : {rem_i[XLEN-1:0], dividend_msb_i};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit with pipeline stall request
// Ports: clk, rst_n (async active-low), bus (div_unit_if.slave: start, funct3, operand_a,
//        operand_b, flush in; indication, result, result_valid out)
module div_unit
  import riscv_mdu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  div_state_t      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, a_neg, b_neg, accept, div_zero, overflow;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [XLEN:0]   step_rem;
  logic            step_bit;

  assign is_signed = ~bus.funct3[0];
  assign a_neg     = is_signed & bus.operand_a[XLEN-1];
  assign b_neg     = is_signed & bus.operand_b[XLEN-1];
  assign abs_a     = a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign abs_b     = b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;

  assign accept    = (state_q == IDLE) & bus.start & bus.funct3[2] & ~bus.flush;
  assign div_zero  = (bus.operand_b == '0);
  assign overflow  = is_signed & (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.operand_b == '1);

  // Divide-by-zero takes priority; only reached for overflow when b != 0.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.operand_a : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  div_step u_step (
    .rem_i          (rem_q),
    .dividend_msb_i (dividend_q[XLEN-1]),
    .divisor_i      (divisor_q),
    .rem_o          (step_rem),
    .quot_bit_o     (step_bit)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    result_d   = result_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          is_rem_d   = bus.funct3[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dividend_d = abs_a;
          divisor_d  = abs_b;
          rem_d      = '0;
          quot_d     = '0;
          count_d    = '0;
          if (div_zero || overflow) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d      = step_rem;
        quot_d     = {quot_q[XLEN-2:0], step_bit};
        dividend_d = {dividend_q[XLEN-2:0], 1'b0};
        count_d    = count_q + 5'd1;
        if (count_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (is_rem_q) begin
          result_d = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
        end else begin
          result_d = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
        end
        state_d = DONE;
      end
      DONE: begin
        // The finished instruction is still in ID/EX here, so start is not sampled.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A redirect discards the operation and must not disturb the last result.
    if (bus.flush) begin
      state_d  = IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      result_q   <= result_d;
    end
  end

  // Stall is asserted in the accept cycle itself so ID/EX holds the operands.
  assign bus.indication   = rst_n & ~bus.flush
                          & (accept | (state_q == BUSY) | (state_q == FIX));
  assign bus.result_valid = (state_q == DONE) & ~bus.flush;
  assign bus.result       = result_q;

endmodule
